soc_system_pio_ext: RTL and testbench

Parametrised Avalon-MM slave PIO, the next generation of the fixed 8-bit output-only PIO.
- Provides a width-configurable output register with atomic bit set/clear aliases.
- Adds a synchronised input port with per-bit edge capture, an interrupt mask and a level interrupt to the HPS/Nios.
- Sits on the lightweight bridge alongside the existing PIOs.

---
 rtl/soc_system_pio_ext.sv | 95 +++++++++
 tb/tb_soc_system_pio_ext.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_pio_ext.sv
// Avalon-MM slave PIO: width-configurable output register with set/clear aliases,
// synchronised input port with per-bit edge capture, interrupt mask and level irq.
module soc_system_pio_ext #(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = {DATA_WIDTH{1'b1}},
    parameter int                    EDGE_TYPE   = 0,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [DATA_WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [DATA_WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] prev_q;
    logic [DATA_WIDTH-1:0] in_sync;
    logic [DATA_WIDTH-1:0] det;
    logic [DATA_WIDTH-1:0] clr_mask;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wr;
    logic                  unused_wdata;

    assign wr           = chipselect & ~write_n;
    assign wdata        = writedata[DATA_WIDTH-1:0];
    assign unused_wdata = &{1'b0, writedata};
    assign in_sync      = sync_q[SYNC_STAGES-1];

    always_comb begin
        case (EDGE_TYPE)
            0:       det = in_sync & ~prev_q;
            1:       det = ~in_sync & prev_q;
            default: det = in_sync ^ prev_q;
        endcase
    end

    always_comb begin
        data_out_d = data_out_q;
        irq_mask_d = irq_mask_q;
        clr_mask   = '0;
        if (wr) begin
            case (address)
                3'd0:    data_out_d = wdata;
                3'd2:    irq_mask_d = wdata;
                3'd3:    clr_mask   = wdata;
                3'd4:    data_out_d = data_out_q | wdata;
                3'd5:    data_out_d = data_out_q & ~wdata;
                default: ;
            endcase
        end
        // A detection in the same cycle as a W1C on that bit keeps the bit set.
        edge_cap_d = (edge_cap_q & ~clr_mask) | det;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q <= RESET_VALUE;
            irq_mask_q <= '0;
            edge_cap_q <= '0;
            prev_q     <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            data_out_q <= data_out_d;
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
            prev_q     <= in_sync;
            sync_q[0]  <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            3'd0:    readdata[DATA_WIDTH-1:0] = data_out_q;
            3'd1:    readdata[DATA_WIDTH-1:0] = in_sync;
            3'd2:    readdata[DATA_WIDTH-1:0] = irq_mask_q;
            3'd3:    readdata[DATA_WIDTH-1:0] = edge_cap_q;
            default: readdata = '0;
        endcase
    end

    assign out_port = data_out_q;
    assign irq      = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_soc_system_pio_ext.sv
// Directed bench for soc_system_pio_ext: rising/falling/any 8-bit instances sharing
// one bus, plus a 32-bit instance with RESET_VALUE=0.
module tb_soc_system_pio_ext;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        write_n;
    logic        cs8, cs32;
    logic [31:0] writedata;
    logic [7:0]  in8;
    logic [31:0] in32;
    logic [31:0] rd_r, rd_f, rd_a, rd_w;
    logic [7:0]  out_r, out_f, out_a;
    logic [31:0] out_w;
    logic        irq_r, irq_f, irq_a, irq_w;

    int compared   = 0;
    int mismatched = 0;

    soc_system_pio_ext #(.DATA_WIDTH(8), .EDGE_TYPE(0)) dut_r (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs8),
        .write_n(write_n), .writedata(writedata), .readdata(rd_r),
        .in_port(in8), .out_port(out_r), .irq(irq_r));
    soc_system_pio_ext #(.DATA_WIDTH(8), .EDGE_TYPE(1)) dut_f (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs8),
        .write_n(write_n), .writedata(writedata), .readdata(rd_f),
        .in_port(in8), .out_port(out_f), .irq(irq_f));
    soc_system_pio_ext #(.DATA_WIDTH(8), .EDGE_TYPE(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs8),
        .write_n(write_n), .writedata(writedata), .readdata(rd_a),
        .in_port(in8), .out_port(out_a), .irq(irq_a));
    soc_system_pio_ext #(.DATA_WIDTH(32), .RESET_VALUE(32'h0), .EDGE_TYPE(0)) dut_w (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs32),
        .write_n(write_n), .writedata(writedata), .readdata(rd_w),
        .in_port(in32), .out_port(out_w), .irq(irq_w));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All tasks are entered just after a falling edge and return just after one.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic sel32);
        address   = a;
        writedata = d;
        cs8       = !sel32;
        cs32      = sel32;
        write_n   = 1'b0;
        @(negedge clk);
        write_n   = 1'b1;
        cs8       = 1'b0;
        cs32      = 1'b0;
    endtask

    task automatic set_addr(input logic [2:0] a);
        address = a;
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; address = 3'd0; write_n = 1'b1; cs8 = 1'b0; cs32 = 1'b0;
        writedata = '0; in8 = '0; in32 = '0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
        compared++; if (out_r !== 8'hFF) begin mismatched++; $display("FAIL reset_out: got %h want ff", out_r); end
        set_addr(3'd0);
        compared++; if (rd_r !== 32'h000000FF) begin mismatched++; $display("FAIL reset_rd0: got %h want 000000ff", rd_r); end
        compared++; if (irq_r !== 1'b0) begin mismatched++; $display("FAIL reset_irq: got %b want 0", irq_r); end
        set_addr(3'd2);
        compared++; if (rd_r !== 32'h0) begin mismatched++; $display("FAIL reset_rd2: got %h want 0", rd_r); end
        set_addr(3'd3);
        compared++; if (rd_r !== 32'h0) begin mismatched++; $display("FAIL reset_rd3: got %h want 0", rd_r); end
        compared++; if (out_w !== 32'h0) begin mismatched++; $display("FAIL reset_out32: got %h want 0", out_w); end
    endtask

    task automatic test_data_out;
        wr(3'd0, 32'hABCDEF5A, 1'b0);
        compared++; if (out_r !== 8'h5A) begin mismatched++; $display("FAIL data_write: got %h want 5a", out_r); end
        wr(3'd4, 32'h00000081, 1'b0);
        compared++; if (out_r !== 8'hDB) begin mismatched++; $display("FAIL out_set: got %h want db", out_r); end
        wr(3'd5, 32'h00000018, 1'b0);
        compared++; if (out_r !== 8'hC3) begin mismatched++; $display("FAIL out_clr: got %h want c3", out_r); end
        set_addr(3'd4);
        compared++; if (rd_r !== 32'h0) begin mismatched++; $display("FAIL rd_set_alias: got %h want 0", rd_r); end
        set_addr(3'd5);
        compared++; if (rd_r !== 32'h0) begin mismatched++; $display("FAIL rd_clr_alias: got %h want 0", rd_r); end
        set_addr(3'd0);
        compared++; if (rd_r !== 32'h000000C3) begin mismatched++; $display("FAIL rd_data: got %h want 000000c3", rd_r); end
        tick(1);
        wr(3'd4, 32'h0, 1'b0);
        wr(3'd5, 32'h0, 1'b0);
        compared++; if (out_r !== 8'hC3) begin mismatched++; $display("FAIL setclr_zero: got %h want c3", out_r); end
        wr(3'd6, 32'h000000FF, 1'b0);
        compared++; if (out_r !== 8'hC3) begin mismatched++; $display("FAIL reserved_wr: got %h want c3", out_r); end
        set_addr(3'd6);
        compared++; if (rd_r !== 32'h0) begin mismatched++; $display("FAIL reserved_rd: got %h want 0", rd_r); end
        tick(1);
    endtask

    task automatic test_rising_irq;
        wr(3'd2, 32'h01, 1'b0);
        set_addr(3'd2);
        compared++; if (rd_r !== 32'h01) begin mismatched++; $display("FAIL mask_rd: got %h want 01", rd_r); end
        tick(1);
        in8[0] = 1'b1;
        tick(1);
        compared++; if (irq_r !== 1'b0) begin mismatched++; $display("FAIL irq_k: got %b want 0", irq_r); end
        tick(1);
        compared++; if (irq_r !== 1'b0) begin mismatched++; $display("FAIL irq_k1: got %b want 0", irq_r); end
        tick(1);
        compared++; if (irq_r !== 1'b1) begin mismatched++; $display("FAIL irq_k2: got %b want 1", irq_r); end
        set_addr(3'd3);
        compared++; if (rd_r !== 32'h01) begin mismatched++; $display("FAIL cap_k2: got %h want 01", rd_r); end
        set_addr(3'd1);
        compared++; if (rd_r !== 32'h01) begin mismatched++; $display("FAIL input_rd: got %h want 01", rd_r); end
        tick(1);
        wr(3'd3, 32'h01, 1'b0);
        compared++; if (irq_r !== 1'b0) begin mismatched++; $display("FAIL irq_w1c: got %b want 0", irq_r); end
        set_addr(3'd3);
        compared++; if (rd_r !== 32'h0) begin mismatched++; $display("FAIL cap_w1c: got %h want 0", rd_r); end
        tick(1);
    endtask

    task automatic test_set_wins;
        in8[0] = 1'b0; tick(4);
        in8[0] = 1'b1; tick(4);
        set_addr(3'd3);
        compared++; if (rd_r !== 32'h01) begin mismatched++; $display("FAIL cap_pre: got %h want 01", rd_r); end
        tick(1);
        in8[0] = 1'b0; tick(4);
        in8[0] = 1'b1; tick(2);
        wr(3'd3, 32'h01, 1'b0);
        set_addr(3'd3);
        compared++; if (rd_r !== 32'h01) begin mismatched++; $display("FAIL set_wins_cap: got %h want 01", rd_r); end
        compared++; if (irq_r !== 1'b1) begin mismatched++; $display("FAIL set_wins_irq: got %b want 1", irq_r); end
        tick(1);
        wr(3'd3, 32'h01, 1'b0);
        compared++; if (irq_r !== 1'b0) begin mismatched++; $display("FAIL w1c_after: got %b want 0", irq_r); end
    endtask

    task automatic test_mask;
        in8[1] = 1'b1; tick(4);
        set_addr(3'd3);
        compared++; if (rd_r !== 32'h02) begin mismatched++; $display("FAIL cap_masked: got %h want 02", rd_r); end
        compared++; if (irq_r !== 1'b0) begin mismatched++; $display("FAIL irq_masked: got %b want 0", irq_r); end
        tick(1);
        wr(3'd2, 32'h03, 1'b0);
        compared++; if (irq_r !== 1'b1) begin mismatched++; $display("FAIL irq_unmask: got %b want 1", irq_r); end
        wr(3'd2, 32'h01, 1'b0);
        compared++; if (irq_r !== 1'b0) begin mismatched++; $display("FAIL irq_remask: got %b want 0", irq_r); end
        set_addr(3'd3);
        compared++; if (rd_r !== 32'h02) begin mismatched++; $display("FAIL cap_kept: got %h want 02", rd_r); end
        tick(1);
    endtask

    task automatic test_edge_types;
        wr(3'd3, 32'hFF, 1'b0);
        in8[2] = 1'b1; tick(4);
        set_addr(3'd3);
        compared++; if (rd_r !== 32'h04) begin mismatched++; $display("FAIL rise_r: got %h want 04", rd_r); end
        compared++; if (rd_f !== 32'h00) begin mismatched++; $display("FAIL rise_f: got %h want 00", rd_f); end
        compared++; if (rd_a !== 32'h04) begin mismatched++; $display("FAIL rise_a: got %h want 04", rd_a); end
        tick(1);
        wr(3'd3, 32'hFF, 1'b0);
        in8[2] = 1'b0; tick(4);
        set_addr(3'd3);
        compared++; if (rd_r !== 32'h00) begin mismatched++; $display("FAIL fall_r: got %h want 00", rd_r); end
        compared++; if (rd_f !== 32'h04) begin mismatched++; $display("FAIL fall_f: got %h want 04", rd_f); end
        compared++; if (rd_a !== 32'h04) begin mismatched++; $display("FAIL fall_a: got %h want 04", rd_a); end
        compared++; if (irq_f !== 1'b0) begin mismatched++; $display("FAIL fall_irq_f: got %b want 0", irq_f); end
        tick(1);
        wr(3'd3, 32'hFF, 1'b0);
        in8[3] = 1'b1; tick(3);
        in8[3] = 1'b0; tick(5);
        set_addr(3'd3);
        compared++; if (rd_r !== 32'h08) begin mismatched++; $display("FAIL pulse_r: got %h want 08", rd_r); end
        compared++; if (rd_f !== 32'h08) begin mismatched++; $display("FAIL pulse_f: got %h want 08", rd_f); end
        compared++; if (rd_a !== 32'h08) begin mismatched++; $display("FAIL pulse_a: got %h want 08", rd_a); end
        tick(1);
    endtask

    task automatic test_wide_and_reset;
        wr(3'd0, 32'hDEADBEEF, 1'b1);
        set_addr(3'd0);
        compared++; if (rd_w !== 32'hDEADBEEF) begin mismatched++; $display("FAIL wide_rd: got %h want deadbeef", rd_w); end
        compared++; if (out_w !== 32'hDEADBEEF) begin mismatched++; $display("FAIL wide_out: got %h want deadbeef", out_w); end
        compared++; if (out_r !== 8'hC3) begin mismatched++; $display("FAIL wide_isolated: got %h want c3", out_r); end
        tick(1);
        wr(3'd2, 32'h80000000, 1'b1);
        in32[31] = 1'b1; tick(4);
        set_addr(3'd3);
        compared++; if (rd_w !== 32'h80000000) begin mismatched++; $display("FAIL wide_cap: got %h want 80000000", rd_w); end
        compared++; if (irq_w !== 1'b1) begin mismatched++; $display("FAIL wide_irq: got %b want 1", irq_w); end
        tick(1);
        address = 3'd0; writedata = 32'h12345678; cs32 = 1'b1; write_n = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        compared++; if (out_w !== 32'h0) begin mismatched++; $display("FAIL rst_out32: got %h want 0", out_w); end
        compared++; if (irq_w !== 1'b0) begin mismatched++; $display("FAIL rst_irq32: got %b want 0", irq_w); end
        compared++; if (out_r !== 8'hFF) begin mismatched++; $display("FAIL rst_out8: got %h want ff", out_r); end
        set_addr(3'd3);
        compared++; if (rd_w !== 32'h0) begin mismatched++; $display("FAIL rst_cap32: got %h want 0", rd_w); end
        compared++; if (rd_a !== 32'h0) begin mismatched++; $display("FAIL rst_cap_a: got %h want 0", rd_a); end
        write_n = 1'b1; cs32 = 1'b0;
        tick(2);
        reset_n = 1'b1;
        #1;
        compared++; if (rd_w !== 32'h0) begin mismatched++; $display("FAIL rel_cap32: got %h want 0", rd_w); end
        compared++; if (out_w !== 32'h0) begin mismatched++; $display("FAIL rel_out32: got %h want 0", out_w); end
    endtask

    initial begin
        test_reset();
        test_data_out();
        test_rising_irq();
        test_set_wins();
        test_mask();
        test_edge_types();
        test_wide_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
